// File: rtl/led_event_blinker_pkg.sv
// Shared types and elaboration helpers for the LED event blinker and
// the millisecond timer it drives.
package led_event_blinker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  function automatic longint ms_to_cycles(input longint ms, input longint freq_mhz);
    return ms * 64'sd1000 * freq_mhz;
  endfunction

  // Largest value a cnt_w-bit saturating counter may hold.
  function automatic int cnt_max(input int cnt_w);
    return int'((32'd1 << cnt_w) - 32'd1);
  endfunction

endpackage

// File: rtl/led_event_blinker_timer.sv
// Clearable up-counter with a terminal-count flag against a runtime limit;
// shared with the button debounce path.
module ms_timer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic [N-1:0] limit_i,
  output logic         tc_o
);

  logic [N-1:0] count_q;
  logic [N-1:0] count_d;

  // Next count: clear wins over enable.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + N'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = en_i && (count_q == (limit_i - N'(1)));

endmodule

// File: rtl/led_event_blinker.sv
// Turns single-cycle event strobes into countable LED blinks (ON period then
// dark gap), queuing events that arrive mid-blink in a saturating counter.
module led_event_blinker
  import led_event_blinker_pkg::*;
#(
  parameter int   N          = 32,
  parameter int   FREQ       = 50,
  parameter int   ON_MS      = 100,
  parameter int   OFF_MS     = 100,
  parameter int   CNT_W      = 4,
  parameter logic LED_ACTIVE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             evt_in,
  output logic             led_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
);

  localparam longint ON_CYC  = ms_to_cycles(longint'(ON_MS), longint'(FREQ));
  localparam longint OFF_CYC = ms_to_cycles(longint'(OFF_MS), longint'(FREQ));
  localparam longint TMR_MAX = (64'sd1 << N) - 64'sd1;

  if (ON_CYC < 64'sd1 || ON_CYC > TMR_MAX) begin : g_on_cycles_invalid
    $error("led_event_blinker: ON_CYCLES must be in 1..2^N-1");
  end
  if (OFF_CYC < 64'sd1 || OFF_CYC > TMR_MAX) begin : g_off_cycles_invalid
    $error("led_event_blinker: OFF_CYCLES must be in 1..2^N-1");
  end

  localparam logic [N-1:0]     ON_LIMIT  = N'(ON_CYC);
  localparam logic [N-1:0]     OFF_LIMIT = N'(OFF_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(cnt_max(CNT_W));

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             led_q, led_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic             consume_direct;
  logic             dec;
  logic             inc;
  logic             tmr_clear;
  logic             tmr_en;
  logic             tmr_tc;
  logic [N-1:0]     tmr_limit;

  assign tmr_limit = (state_q == ST_OFF) ? OFF_LIMIT : ON_LIMIT;
  assign tmr_en    = (state_q != ST_IDLE);
  assign tmr_clear = (state_d != state_q);

  ms_timer #(
    .N (N)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (tmr_clear),
    .en_i    (tmr_en),
    .limit_i (tmr_limit),
    .tc_o    (tmr_tc)
  );

  // State transitions; at the end of a gap a queued event has priority
  // over a live strobe, which then gets queued instead.
  always_comb begin
    state_d        = state_q;
    consume_direct = 1'b0;
    dec            = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (evt_in) begin
          state_d        = ST_ON;
          consume_direct = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ON: begin
        if (tmr_tc) begin
          state_d = ST_OFF;
        end else begin
          state_d = ST_ON;
        end
      end
      ST_OFF: begin
        if (!tmr_tc) begin
          state_d = ST_OFF;
        end else if (pend_q != '0) begin
          state_d = ST_ON;
          dec     = 1'b1;
        end else if (evt_in) begin
          state_d        = ST_ON;
          consume_direct = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign inc = evt_in && !consume_direct;

  // Saturating pending counter; a simultaneous consume makes room, so no drop.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = 1'b0;
    if (inc && !dec) begin
      if (pend_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + CNT_W'(1);
      end
    end else if (dec && !inc) begin
      pend_d = pend_q - CNT_W'(1);
    end else begin
      pend_d = pend_q;
    end
  end

  // Output drives follow the next state so they line up with it.
  always_comb begin
    led_d  = (state_d == ST_ON) ? LED_ACTIVE : ~LED_ACTIVE;
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      led_q   <= ~LED_ACTIVE;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign led_out  = led_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_led_event_blinker.sv
// Directed bench for led_event_blinker with 1000-cycle ON and OFF periods
// and a 2-bit pending counter.
module tb_led_event_blinker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       evt_in = 1'b0;
  logic       led_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int blinks = 0;
  int ovf_cnt = 0;
  logic prev_led = 1'b0;

  led_event_blinker #(
    .N          (32),
    .FREQ       (1),
    .ON_MS      (1),
    .OFF_MS     (1),
    .CNT_W      (2),
    .LED_ACTIVE (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .evt_in   (evt_in),
    .led_out  (led_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  // One clock; observe at the falling edge, count blinks and drops.
  task automatic adv();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    evt_in = 1'b0;
    if (led_out === 1'b1 && prev_led === 1'b0) blinks++;
    if (overflow === 1'b1) ovf_cnt++;
    prev_led = led_out;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) adv();
  endtask

  task automatic pulse_at(input int c);
    run_to(c);
    evt_in = 1'b1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    evt_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_led", 32'(led_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    cyc = 0;
    blinks = 0;
    ovf_cnt = 0;
    prev_led = 1'b0;
  endtask

  initial begin
    // Single event
    apply_reset();
    pulse_at(10);
    chk("s_led_before", 32'(led_out), 32'd0);
    run_to(11);
    chk("s_led_on_first", 32'(led_out), 32'd1);
    chk("s_busy_on", 32'(busy), 32'd1);
    chk("s_pending", 32'(pending), 32'd0);
    run_to(1010);
    chk("s_led_on_last", 32'(led_out), 32'd1);
    run_to(1011);
    chk("s_led_off_first", 32'(led_out), 32'd0);
    chk("s_busy_off", 32'(busy), 32'd1);
    run_to(2010);
    chk("s_busy_gap_last", 32'(busy), 32'd1);
    run_to(2011);
    chk("s_busy_idle", 32'(busy), 32'd0);
    run_to(2100);
    chk("s_blinks", 32'(blinks), 32'd1);

    // Queued events
    apply_reset();
    pulse_at(10);
    pulse_at(50);
    run_to(51);
    chk("q_pend1", 32'(pending), 32'd1);
    pulse_at(60);
    run_to(61);
    chk("q_pend2", 32'(pending), 32'd2);
    run_to(2010);
    chk("q_pend_before_dec1", 32'(pending), 32'd2);
    chk("q_led_gap", 32'(led_out), 32'd0);
    run_to(2011);
    chk("q_pend_dec1", 32'(pending), 32'd1);
    chk("q_led_blink2", 32'(led_out), 32'd1);
    run_to(4010);
    chk("q_led_gap2", 32'(led_out), 32'd0);
    run_to(4011);
    chk("q_pend_dec2", 32'(pending), 32'd0);
    chk("q_led_blink3", 32'(led_out), 32'd1);
    run_to(6010);
    chk("q_busy_last_gap", 32'(busy), 32'd1);
    run_to(6011);
    chk("q_busy_idle", 32'(busy), 32'd0);
    run_to(6100);
    chk("q_blinks", 32'(blinks), 32'd3);

    // Saturation: five extra events during the first ON period
    apply_reset();
    pulse_at(10);
    pulse_at(20);
    pulse_at(30);
    pulse_at(40);
    run_to(41);
    chk("sat_pend3", 32'(pending), 32'd3);
    chk("sat_no_ovf", 32'(overflow), 32'd0);
    pulse_at(50);
    run_to(51);
    chk("sat_ovf4", 32'(overflow), 32'd1);
    chk("sat_pend_hold", 32'(pending), 32'd3);
    run_to(52);
    chk("sat_ovf_pulse_end", 32'(overflow), 32'd0);
    pulse_at(60);
    run_to(61);
    chk("sat_ovf5", 32'(overflow), 32'd1);
    run_to(8010);
    chk("sat_busy_last_gap", 32'(busy), 32'd1);
    run_to(8011);
    chk("sat_busy_idle", 32'(busy), 32'd0);
    run_to(8100);
    chk("sat_blinks", 32'(blinks), 32'd4);
    chk("sat_ovf_count", 32'(ovf_cnt), 32'd2);

    // Simultaneous increment and decrement at the OFF->ON edge
    apply_reset();
    pulse_at(10);
    pulse_at(20);
    pulse_at(30);
    pulse_at(40);
    pulse_at(2010);
    chk("sim_pend_before", 32'(pending), 32'd3);
    run_to(2011);
    chk("sim_pend_hold", 32'(pending), 32'd3);
    chk("sim_no_ovf", 32'(overflow), 32'd0);
    chk("sim_led_on", 32'(led_out), 32'd1);
    run_to(10011);
    chk("sim_busy_idle", 32'(busy), 32'd0);
    chk("sim_blinks", 32'(blinks), 32'd5);
    chk("sim_ovf_count", 32'(ovf_cnt), 32'd0);

    // Reset mid-blink
    apply_reset();
    pulse_at(10);
    pulse_at(20);
    pulse_at(30);
    run_to(500);
    chk("mr_pend2", 32'(pending), 32'd2);
    chk("mr_led_on", 32'(led_out), 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_led_async", 32'(led_out), 32'd0);
    chk("mr_pend_async", 32'(pending), 32'd0);
    chk("mr_busy_async", 32'(busy), 32'd0);
    adv();
    adv();
    rst = 1'b0;
    cyc = 0;
    blinks = 0;
    prev_led = led_out;
    run_to(3000);
    chk("mr_no_blinks", 32'(blinks), 32'd0);
    chk("mr_busy_after", 32'(busy), 32'd0);

    // Back-to-back at the end of the gap
    apply_reset();
    pulse_at(10);
    pulse_at(2010);
    chk("bb_busy_gap_end", 32'(busy), 32'd1);
    chk("bb_pend0", 32'(pending), 32'd0);
    run_to(2011);
    chk("bb_led_on", 32'(led_out), 32'd1);
    chk("bb_busy", 32'(busy), 32'd1);
    chk("bb_pend_still0", 32'(pending), 32'd0);
    run_to(4011);
    chk("bb_busy_idle", 32'(busy), 32'd0);
    chk("bb_blinks", 32'(blinks), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
